// File: rtl/coherence_ctrl_if.sv
// Bus bundle between the coherence controller, its cache pairs and main memory.
// The controller takes the slave view; caches plus memory take the master view.
interface coherence_ctrl_if #(parameter int CPUS = 2);
    // cache -> controller
    logic [CPUS-1:0]       iREN;
    logic [CPUS-1:0]       dREN;
    logic [CPUS-1:0]       dWEN;
    logic [CPUS-1:0]       ccwrite;
    logic [CPUS-1:0]       cctrans;
    logic [CPUS-1:0][31:0] iaddr;
    logic [CPUS-1:0][31:0] daddr;
    logic [CPUS-1:0][31:0] dstore;
    // controller -> cache
    logic [CPUS-1:0]       iwait;
    logic [CPUS-1:0]       dwait;
    logic [CPUS-1:0][31:0] iload;
    logic [CPUS-1:0][31:0] dload;
    logic [CPUS-1:0]       ccwait;
    logic [CPUS-1:0]       ccinv;
    logic [CPUS-1:0][31:0] ccsnoopaddr;
    // controller <-> memory
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    logic [1:0]            ramstate;

    modport slave (
        input  iREN, dREN, dWEN, ccwrite, cctrans, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, dREN, dWEN, ccwrite, cctrans, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_ctrl.sv
// Snooping coherence controller: arbitrates CPUS cache pairs onto one memory port,
// serving 2-word data blocks (with cache-to-cache transfer) and single-word fetches.
module coherence_ctrl #(
    parameter int CPUS = 2
) (
    input logic            CLK,
    input logic            RST,
    coherence_ctrl_if.slave ccif
);
    localparam int         IW         = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [3:0] {
        IDLE, ARB, SNOOP, C2C1, C2C2, LOAD1, LOAD2, WB1, WB2, INSTR
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt;   // requester R / writer W / fetcher I
    logic [IW-1:0] snp, snp_nxt;       // snooped cache supplying the block
    logic [IW-1:0] dptr, dptr_nxt;
    logic [IW-1:0] iptr, iptr_nxt;
    logic          access;
    logic          data_live;
    logic          unused_cc;

    // cctrans carries no information the controller needs beyond dREN/ccwrite.
    assign unused_cc = |ccif.cctrans;

    // First requester at or after ptr, wrapping.
    function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] reqs,
                                              input logic [IW-1:0]   ptr);
        logic [IW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CPUS;
            if (reqs[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    function automatic logic [IW-1:0] after(input logic [IW-1:0] idx);
        return IW'((int'(idx) + 1) % CPUS);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            owner <= '0;
            snp   <= '0;
            dptr  <= '0;
            iptr  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            snp   <= snp_nxt;
            dptr  <= dptr_nxt;
            iptr  <= iptr_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        snp_nxt          = snp;
        dptr_nxt         = dptr;
        iptr_nxt         = iptr;
        ccif.iwait       = '1;
        ccif.dwait       = '1;
        ccif.iload       = '0;
        ccif.dload       = '0;
        ccif.ccwait      = '0;
        ccif.ccinv       = '0;
        ccif.ccsnoopaddr = '0;
        ccif.ramREN      = 1'b0;
        ccif.ramWEN      = 1'b0;
        ccif.ramaddr     = '0;
        ccif.ramstore    = '0;
        access           = (ccif.ramstate == RAM_ACCESS);
        data_live        = ccif.dREN[owner];

        if (!RST) begin
            // Every other cache is held off and watching the block from SNOOP to the last word.
            if ((state inside {SNOOP, C2C1, C2C2, LOAD1, LOAD2}) && data_live) begin
                for (int s = 0; s < CPUS; s++) begin
                    if (s != int'(owner)) begin
                        ccif.ccwait[s]      = 1'b1;
                        ccif.ccsnoopaddr[s] = ccif.daddr[owner];
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (|ccif.dWEN) begin
                        owner_nxt = rr_pick(ccif.dWEN, dptr);
                        state_nxt = WB1;
                    end else if (|ccif.dREN) begin
                        state_nxt = ARB;
                    end else if (|ccif.iREN) begin
                        owner_nxt = rr_pick(ccif.iREN, iptr);
                        state_nxt = INSTR;
                    end
                end

                ARB: begin
                    if (|ccif.dREN) begin
                        owner_nxt = rr_pick(ccif.dREN, dptr);
                        state_nxt = SNOOP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end

                SNOOP: begin
                    if (!data_live) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LOAD1;
                        for (int s = CPUS - 1; s >= 0; s--) begin
                            if (s != int'(owner)) begin
                                ccif.ccinv[s] = ccif.ccwrite[owner];
                                if (ccif.ccwrite[s]) begin
                                    state_nxt = C2C1;
                                    snp_nxt   = IW'(s);
                                end
                            end
                        end
                    end
                end

                C2C1, C2C2: begin
                    if (!data_live) begin
                        state_nxt = IDLE;
                    end else begin
                        // Dirty block goes to the requester and back to memory in one pass.
                        ccif.dload[owner] = ccif.dstore[snp];
                        ccif.ramWEN       = 1'b1;
                        ccif.ramaddr      = ccif.daddr[snp];
                        ccif.ramstore     = ccif.dstore[snp];
                        if (access) begin
                            ccif.dwait[owner] = 1'b0;
                            ccif.dwait[snp]   = 1'b0;
                            if (state == C2C1) begin
                                state_nxt = C2C2;
                            end else begin
                                state_nxt = IDLE;
                                dptr_nxt  = after(owner);
                            end
                        end
                    end
                end

                LOAD1, LOAD2: begin
                    if (!data_live) begin
                        state_nxt = IDLE;
                    end else begin
                        ccif.ramREN       = 1'b1;
                        ccif.ramaddr      = ccif.daddr[owner];
                        ccif.dload[owner] = ccif.ramload;
                        if (access) begin
                            ccif.dwait[owner] = 1'b0;
                            if (state == LOAD1) begin
                                state_nxt = LOAD2;
                            end else begin
                                state_nxt = IDLE;
                                dptr_nxt  = after(owner);
                            end
                        end
                    end
                end

                WB1, WB2: begin
                    if (!ccif.dWEN[owner]) begin
                        state_nxt = IDLE;
                    end else begin
                        ccif.ramWEN   = 1'b1;
                        ccif.ramaddr  = ccif.daddr[owner];
                        ccif.ramstore = ccif.dstore[owner];
                        if (access) begin
                            ccif.dwait[owner] = 1'b0;
                            if (state == WB1) begin
                                state_nxt = WB2;
                            end else begin
                                state_nxt = IDLE;
                                dptr_nxt  = after(owner);
                            end
                        end
                    end
                end

                INSTR: begin
                    if (!ccif.iREN[owner]) begin
                        state_nxt = IDLE;
                    end else begin
                        ccif.ramREN       = 1'b1;
                        ccif.ramaddr      = ccif.iaddr[owner];
                        ccif.iload[owner] = ccif.ramload;
                        if (access) begin
                            ccif.iwait[owner] = 1'b0;
                            state_nxt         = IDLE;
                            iptr_nxt          = after(owner);
                        end
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coherence_ctrl.sv
// Directed bench for coherence_ctrl: fetch, snooped load, cache-to-cache transfer,
// writeback priority, instruction round-robin, reset abort, memory stall and request drop.
module tb_coherence_ctrl;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    coherence_ctrl_if #(.CPUS(2)) ccif();

    coherence_ctrl #(.CPUS(2)) dut (
        .CLK  (clk),
        .RST  (rst),
        .ccif (ccif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        ccif.iREN     = '0;
        ccif.dREN     = '0;
        ccif.dWEN     = '0;
        ccif.ccwrite  = '0;
        ccif.cctrans  = '0;
        ccif.iaddr    = '0;
        ccif.daddr    = '0;
        ccif.dstore   = '0;
        ccif.ramload  = '0;
        ccif.ramstate = FREE;

        // reset state, even with a request pending
        tick();
        ccif.iREN[0] = 1'b1;
        ccif.iaddr[0] = 32'h100;
        tick();
        settle();
        chk("rst_iwait", 32'(ccif.iwait), 32'h3);
        chk("rst_dwait", 32'(ccif.dwait), 32'h3);
        chk("rst_ramren", 32'(ccif.ramREN), 32'h0);
        chk("rst_ramwen", 32'(ccif.ramWEN), 32'h0);
        chk("rst_ramaddr", ccif.ramaddr, 32'h0);
        chk("rst_ccwait", 32'(ccif.ccwait), 32'h0);
        chk("rst_iload0", ccif.iload[0], 32'h0);

        // instruction fetch, two stall cycles then ACCESS
        rst = 1'b0;
        ccif.ramstate = BUSY;
        settle();
        chk("if_idle_iwait", 32'(ccif.iwait), 32'h3);
        tick();
        settle();
        chk("if_ramren", 32'(ccif.ramREN), 32'h1);
        chk("if_ramaddr", ccif.ramaddr, 32'h100);
        chk("if_busy_iwait", 32'(ccif.iwait), 32'h3);
        tick();
        ccif.ramstate = ACCESS;
        ccif.ramload  = 32'hDEADBEEF;
        settle();
        chk("if_iload0", ccif.iload[0], 32'hDEADBEEF);
        chk("if_iwait", 32'(ccif.iwait), 32'h2);
        chk("if_iload1", ccif.iload[1], 32'h0);
        tick();
        ccif.iREN = '0;
        ccif.ramstate = FREE;
        settle();
        chk("if_done_iwait", 32'(ccif.iwait), 32'h3);
        chk("if_done_ramren", 32'(ccif.ramREN), 32'h0);

        // data read by cache0, cache1 silent
        ccif.dREN[0] = 1'b1;
        ccif.cctrans[0] = 1'b1;
        ccif.daddr[0] = 32'h200;
        tick();
        settle();
        chk("ld_arb_ccwait", 32'(ccif.ccwait), 32'h0);
        chk("ld_arb_ramren", 32'(ccif.ramREN), 32'h0);
        tick();
        settle();
        chk("ld_snoop_ccwait", 32'(ccif.ccwait), 32'h2);
        chk("ld_snoop_addr", ccif.ccsnoopaddr[1], 32'h200);
        chk("ld_snoop_ccinv", 32'(ccif.ccinv), 32'h0);
        tick();
        settle();
        chk("ld1_ramren", 32'(ccif.ramREN), 32'h1);
        chk("ld1_ramaddr", ccif.ramaddr, 32'h200);
        chk("ld1_stall_dwait", 32'(ccif.dwait), 32'h3);
        ccif.ramstate = ACCESS;
        ccif.ramload  = 32'h000000A0;
        settle();
        chk("ld1_dload", ccif.dload[0], 32'hA0);
        chk("ld1_dwait", 32'(ccif.dwait), 32'h2);
        tick();
        ccif.daddr[0] = 32'h204;
        ccif.ramload  = 32'h000000A1;
        settle();
        chk("ld2_ramaddr", ccif.ramaddr, 32'h204);
        chk("ld2_dload", ccif.dload[0], 32'hA1);
        chk("ld2_dwait", 32'(ccif.dwait), 32'h2);
        chk("ld2_ccwait", 32'(ccif.ccwait), 32'h2);
        tick();
        ccif.dREN = '0;
        ccif.cctrans = '0;
        ccif.ramstate = FREE;
        settle();
        chk("ld_done_ccwait", 32'(ccif.ccwait), 32'h0);
        chk("ld_done_ramren", 32'(ccif.ramREN), 32'h0);

        // cache1 write-miss, cache0 supplies the modified block
        ccif.dREN[1] = 1'b1;
        ccif.ccwrite[1] = 1'b1;
        ccif.daddr[1] = 32'h300;
        tick();
        tick();
        settle();
        chk("c2c_ccinv", 32'(ccif.ccinv), 32'h1);
        chk("c2c_ccwait", 32'(ccif.ccwait), 32'h1);
        chk("c2c_snoopaddr", ccif.ccsnoopaddr[0], 32'h300);
        ccif.ccwrite[0] = 1'b1;
        ccif.daddr[0] = 32'h300;
        ccif.dstore[0] = 32'h11;
        tick();
        settle();
        chk("c2c1_ccinv", 32'(ccif.ccinv), 32'h0);
        chk("c2c1_dload", ccif.dload[1], 32'h11);
        chk("c2c1_ramwen", 32'(ccif.ramWEN), 32'h1);
        chk("c2c1_ramren", 32'(ccif.ramREN), 32'h0);
        chk("c2c1_ramaddr", ccif.ramaddr, 32'h300);
        chk("c2c1_ramstore", ccif.ramstore, 32'h11);
        chk("c2c1_stall_dwait", 32'(ccif.dwait), 32'h3);
        ccif.ramstate = ACCESS;
        settle();
        chk("c2c1_dwait", 32'(ccif.dwait), 32'h0);
        tick();
        ccif.dstore[0] = 32'h22;
        ccif.daddr[0] = 32'h304;
        ccif.daddr[1] = 32'h304;
        settle();
        chk("c2c2_dload", ccif.dload[1], 32'h22);
        chk("c2c2_ramstore", ccif.ramstore, 32'h22);
        chk("c2c2_ramaddr", ccif.ramaddr, 32'h304);
        chk("c2c2_ccwait", 32'(ccif.ccwait), 32'h1);
        tick();
        ccif.dREN = '0;
        ccif.ccwrite = '0;
        ccif.ramstate = FREE;
        settle();
        chk("c2c_done_ramwen", 32'(ccif.ramWEN), 32'h0);

        // writeback beats a simultaneous fetch
        ccif.dWEN[0] = 1'b1;
        ccif.daddr[0] = 32'h400;
        ccif.dstore[0] = 32'h55;
        ccif.iREN[1] = 1'b1;
        ccif.iaddr[1] = 32'h500;
        ccif.ramstate = ACCESS;
        tick();
        settle();
        chk("wb1_ramwen", 32'(ccif.ramWEN), 32'h1);
        chk("wb1_ramren", 32'(ccif.ramREN), 32'h0);
        chk("wb1_ramaddr", ccif.ramaddr, 32'h400);
        chk("wb1_ramstore", ccif.ramstore, 32'h55);
        chk("wb1_dwait", 32'(ccif.dwait), 32'h2);
        chk("wb1_iwait", 32'(ccif.iwait), 32'h3);
        tick();
        ccif.daddr[0] = 32'h404;
        ccif.dstore[0] = 32'h66;
        settle();
        chk("wb2_ramaddr", ccif.ramaddr, 32'h404);
        chk("wb2_ramstore", ccif.ramstore, 32'h66);
        tick();
        ccif.dWEN = '0;
        ccif.ramload = 32'h77;
        settle();
        chk("wb_done_ramwen", 32'(ccif.ramWEN), 32'h0);
        tick();
        settle();
        chk("wbif_ramaddr", ccif.ramaddr, 32'h500);
        chk("wbif_iload1", ccif.iload[1], 32'h77);
        chk("wbif_iwait", 32'(ccif.iwait), 32'h1);
        tick();

        // both fetchers held: grants alternate 0,1,0,1
        ccif.iREN = 2'b11;
        ccif.iaddr[0] = 32'h600;
        for (int g = 0; g < 4; g++) begin
            tick();
            settle();
            chk($sformatf("rr_grant%0d", g), 32'(ccif.iwait), ((g % 2) == 0) ? 32'h2 : 32'h1);
            tick();
        end
        ccif.iREN = '0;

        // reset during LOAD2 aborts the transaction
        ccif.dREN[0] = 1'b1;
        ccif.daddr[0] = 32'h700;
        tick();
        tick();
        tick();
        tick();
        settle();
        chk("rstld2_ramren", 32'(ccif.ramREN), 32'h1);
        rst = 1'b1;
        settle();
        chk("rstld2_hi_ramren", 32'(ccif.ramREN), 32'h0);
        tick();
        settle();
        chk("rstld2_ramren_after", 32'(ccif.ramREN), 32'h0);
        chk("rstld2_dwait", 32'(ccif.dwait), 32'h3);
        chk("rstld2_ccwait", 32'(ccif.ccwait), 32'h0);
        rst = 1'b0;
        ccif.dREN = '0;
        ccif.ramstate = FREE;
        tick();
        settle();
        chk("rstld2_idle_ramren", 32'(ccif.ramREN), 32'h0);

        // ERROR stalls LOAD1, then the requester gives up
        ccif.dREN[0] = 1'b1;
        ccif.daddr[0] = 32'h800;
        ccif.ramstate = ERROR;
        tick();
        tick();
        tick();
        settle();
        chk("err_ramren", 32'(ccif.ramREN), 32'h1);
        chk("err_dwait", 32'(ccif.dwait), 32'h3);
        tick();
        settle();
        chk("err_hold_ramaddr", ccif.ramaddr, 32'h800);
        chk("err_hold_dwait", 32'(ccif.dwait), 32'h3);
        chk("err_hold_ccwait", 32'(ccif.ccwait), 32'h2);
        ccif.dREN = '0;
        settle();
        chk("drop_ccwait", 32'(ccif.ccwait), 32'h0);
        chk("drop_dwait", 32'(ccif.dwait), 32'h3);
        tick();
        ccif.ramstate = FREE;
        settle();
        chk("drop_idle_ramren", 32'(ccif.ramREN), 32'h0);
        chk("drop_idle_iwait", 32'(ccif.iwait), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/coherence_ctrl.md
COHERENCE_CTRL -- requirements
Module: coherence_ctrl

Interface
REQ-001 Parameter CPUS, default 2, number of cache pairs served; all per-cache ports are arrays [CPUS-1:0].
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 iREN, dREN, dWEN, ccwrite, cctrans  in  1 each per cache  request and coherence outputs of each cache.
REQ-005 iaddr, daddr, dstore  in  32 (word_t) per cache  instruction address, data address, data to store.
REQ-006 iwait, dwait  out  1 per cache  high = request not complete this cycle.
REQ-007 iload, dload  out  32 per cache  returned instruction word / data word.
REQ-008 ccwait, ccinv  out  1 per cache  snoop-stall and invalidate to a snooped cache.
REQ-009 ccsnoopaddr  out  32 per cache  address being snooped.
REQ-010 ramREN, ramWEN  out  1  memory read/write strobes.
REQ-011 ramaddr, ramstore  out  32  memory address and write data.
REQ-012 ramload  in  32  memory read data.
REQ-013 ramstate  in  2 (ramstate_t)  FREE=0, BUSY=1, ACCESS=2, ERROR=3; a word completes in the cycle ramstate==ACCESS.

Function
REQ-014 States: IDLE, ARB, SNOOP, C2C1, C2C2, LOAD1, LOAD2, WB1, WB2, INSTR; data blocks are 2 words; requester presents word0 then word1 on daddr.
REQ-015 IDLE: any dWEN -> WB1; else any dREN -> ARB; else any iREN -> INSTR; data always outranks instruction.
REQ-016 Arbitration among simultaneous requesters of the same class is round-robin; one 1-bit pointer per class advances past the granted cache when its transaction ends.
REQ-017 ARB (1 cycle): latch requester index R; -> SNOOP.
REQ-018 SNOOP: for every cache S != R drive ccwait[S]=1, ccsnoopaddr[S]=daddr[R], ccinv[S]=ccwrite[R]; next cycle any S asserting ccwrite -> C2C1 with that S, else -> LOAD1.
REQ-019 ccwait[S] and ccsnoopaddr[S] stay asserted from SNOOP through end of C2C2/LOAD2; ccinv is a single-cycle pulse in SNOOP.
REQ-020 C2C1/C2C2: dload[R]=dstore[S]; ramWEN=1, ramaddr=daddr[S], ramstore=dstore[S]; on ACCESS pulse dwait[R]=0 and dwait[S]=0, advance; C2C2 -> IDLE.
REQ-021 LOAD1/LOAD2: ramREN=1, ramaddr=daddr[R], dload[R]=ramload; on ACCESS dwait[R]=0, advance; LOAD2 -> IDLE.
REQ-022 WB1/WB2: round-robin pick W among dWEN; ramWEN=1, ramaddr=daddr[W], ramstore=dstore[W]; on ACCESS dwait[W]=0; WB2 -> IDLE; no snoop.
REQ-023 INSTR: ramREN=1, ramaddr=iaddr[I], iload[I]=ramload; on ACCESS iwait[I]=0 for one cycle, -> IDLE.
REQ-024 ramREN and ramWEN never high together; with no active transaction both are 0.
REQ-025 Non-served caches: iwait=dwait=1, iload=dload=0.
REQ-026 Requester dropping its request mid-transaction: controller returns to IDLE next cycle without asserting its wait low; ccwait deasserts.
REQ-027 ramstate ERROR or BUSY: hold state and outputs, no completion.
REQ-028 Only one transaction outstanding; a request arriving during another waits with wait=1.

Reset
REQ-029 While RST=1: state IDLE, both RR pointers 0, ramREN=ramWEN=0, ramaddr=ramstore=0, all iwait=dwait=1, ccwait=ccinv=0, ccsnoopaddr=0, iload=dload=0.
REQ-030 RST asserted mid-transaction aborts it in the same clock edge; no further ram strobes.

Verification
REQ-031 iREN[0]=1, iaddr=0x100, ramstate ACCESS after 2 cycles with ramload=0xDEADBEEF -> iload[0]=0xDEADBEEF, iwait[0]=0 one cycle.
REQ-032 dREN[0], cctrans[0], daddr=0x200, cache1 silent -> ccwait[1]=1, ccsnoopaddr[1]=0x200, two RAM reads, dwait[0] low twice, IDLE.
REQ-033 dREN[1] with ccwrite[1]=1, cache0 holds M and raises ccwrite[0], dstore[0]=0x11,0x22 -> ccinv[0] pulse, dload[1]=0x11 then 0x22, RAM written 0x11/0x22.
REQ-034 dWEN[0] and iREN[1] same cycle -> writeback of 2 words first, then instruction fetch for cache1.
REQ-035 iREN[0] and iREN[1] held continuously -> grants alternate 0,1,0,1.
REQ-036 RST high during LOAD2 -> next cycle IDLE, ramREN=0, all waits 1.
